// File: rtl/dma32_pkg.sv
// Shared definitions for the DMA load stage.
//   state_t          : load-stage FSM states; encoding is visible on debug[31:29]
//   DMA_SIZE_WORD    : DMA beat size code for 32-bit words
//   DMA_USER_DEFAULT : user field sent with every read request
//   DEFAULT_*        : parameter defaults for dma32_load_stage
//   min_u32          : unsigned minimum, used for burst length selection
package dma32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0]  DMA_SIZE_WORD       = 3'b010;
    localparam logic [4:0]  DMA_USER_DEFAULT    = 5'd0;
    localparam int unsigned DEFAULT_BURST_WORDS = 8;
    localparam int unsigned DEFAULT_FIFO_DEPTH  = 16;

    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/dma32_sync_fifo.sv
// Single-clock FIFO with show-ahead read port.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_data   : write strobe and word; ignored when full
//   i_pop            : read strobe; ignored when empty
//   o_data           : current head word (valid while !o_empty)
//   o_empty, o_count : occupancy status
module dma32_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != DEPTH_CNT);
    assign w_do_pop  = i_pop && (r_count != '0);

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/dma32_load_stage.sv
// DMA load stage: fetches N consecutive 32-bit words starting at a base word
// index through burst read requests, buffers them, and streams them out.
//   clk, rst                 : clock, asynchronous active-low reset
//   conf_done, conf_info_*   : start pulse, word count N (reg0), base index (reg1)
//   dma_read_ctrl_*          : burst read request channel (valid/ready)
//   dma_read_chnl_*          : read data beats from memory (valid/ready)
//   out_valid/ready/data/last: word stream to compute stage; last marks word N
//   load_done                : one-cycle completion pulse
//   debug                    : {state[2:0], words delivered[28:0]}
module dma32_load_stage
    import dma32_pkg::*;
#(
    parameter int unsigned BURST_WORDS = DEFAULT_BURST_WORDS,
    parameter int unsigned FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        conf_done,
    input  logic [31:0] conf_info_reg0,
    input  logic [31:0] conf_info_reg1,
    output logic        dma_read_ctrl_valid,
    input  logic        dma_read_ctrl_ready,
    output logic [31:0] dma_read_ctrl_data_index,
    output logic [31:0] dma_read_ctrl_data_length,
    output logic [2:0]  dma_read_ctrl_data_size,
    output logic [4:0]  dma_read_ctrl_data_user,
    input  logic        dma_read_chnl_valid,
    output logic        dma_read_chnl_ready,
    input  logic [31:0] dma_read_chnl_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        load_done,
    output logic [31:0] debug
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t      r_state;
    logic [31:0] r_n;
    logic [31:0] r_base;
    logic [31:0] r_req_cnt;
    logic [31:0] r_out_cnt;
    logic [31:0] r_beat;
    logic        r_ctrl_valid;
    logic [31:0] r_ctrl_index;
    logic [31:0] r_ctrl_length;
    logic [2:0]  r_ctrl_size;
    logic [4:0]  r_ctrl_user;
    logic        r_load_done;

    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [31:0]   w_fifo_data;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_free;
    logic [31:0]   w_len;

    assign w_push = (r_state == ST_DATA) && dma_read_chnl_valid;
    assign w_pop  = !w_fifo_empty && out_ready;
    assign w_free = 32'(FIFO_DEPTH) - 32'(w_fifo_count);
    assign w_len  = min_u32(r_n - r_req_cnt, 32'(BURST_WORDS));

    dma32_sync_fifo #(
        .WIDTH(32),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  (dma_read_chnl_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_n           <= '0;
            r_base        <= '0;
            r_req_cnt     <= '0;
            r_out_cnt     <= '0;
            r_beat        <= '0;
            r_ctrl_valid  <= 1'b0;
            r_ctrl_index  <= '0;
            r_ctrl_length <= '0;
            r_ctrl_size   <= '0;
            r_ctrl_user   <= '0;
            r_load_done   <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + 32'd1;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (conf_done) begin
                        r_n    <= conf_info_reg0;
                        r_base <= conf_info_reg1;
                        if (conf_info_reg0 == '0) begin
                            r_state     <= ST_DONE;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // No pushes happen in REQ, so free space can only grow
                    // while the request waits for ready: fields stay valid.
                    if (!r_ctrl_valid) begin
                        if (w_free >= w_len) begin
                            r_ctrl_valid  <= 1'b1;
                            r_ctrl_index  <= r_base + r_req_cnt;
                            r_ctrl_length <= w_len;
                            r_ctrl_size   <= DMA_SIZE_WORD;
                            r_ctrl_user   <= DMA_USER_DEFAULT;
                        end
                    end else if (dma_read_ctrl_ready) begin
                        r_ctrl_valid <= 1'b0;
                        r_req_cnt    <= r_req_cnt + r_ctrl_length;
                        r_beat       <= '0;
                        r_state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (dma_read_chnl_valid) begin
                        r_beat <= r_beat + 32'd1;
                        if (r_beat == r_ctrl_length - 32'd1) begin
                            r_state <= (r_req_cnt == r_n) ? ST_DRAIN : ST_REQ;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && out_last) begin
                        r_state     <= ST_DONE;
                        r_load_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_n       <= '0;
                    r_base    <= '0;
                    r_req_cnt <= '0;
                    r_out_cnt <= '0;
                    r_beat    <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dma_read_ctrl_valid       = r_ctrl_valid;
    assign dma_read_ctrl_data_index  = r_ctrl_index;
    assign dma_read_ctrl_data_length = r_ctrl_length;
    assign dma_read_ctrl_data_size   = r_ctrl_size;
    assign dma_read_ctrl_data_user   = r_ctrl_user;
    assign dma_read_chnl_ready       = (r_state == ST_DATA);
    assign out_valid                 = !w_fifo_empty;
    assign out_data                  = w_fifo_data;
    // Head is word number r_out_cnt+1; it is the last one when that equals N.
    assign out_last                  = !w_fifo_empty && ((r_out_cnt + 32'd1) == r_n);
    assign load_done                 = r_load_done;
    assign debug                     = {r_state, r_out_cnt[28:0]};

endmodule

// File: tb/tb_dma32_load_stage.sv
module tb_dma32_load_stage;

    localparam int unsigned BW = 8;
    localparam int unsigned FD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        conf_done = 1'b0;
    logic [31:0] conf_info_reg0 = '0;
    logic [31:0] conf_info_reg1 = '0;
    logic        dma_read_ctrl_valid;
    logic        dma_read_ctrl_ready = 1'b0;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic [4:0]  dma_read_ctrl_data_user;
    logic        dma_read_chnl_valid = 1'b0;
    logic        dma_read_chnl_ready;
    logic [31:0] dma_read_chnl_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        load_done;
    logic [31:0] debug;

    always #5 clk = ~clk;

    dma32_load_stage #(
        .BURST_WORDS(BW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .conf_done                 (conf_done),
        .conf_info_reg0            (conf_info_reg0),
        .conf_info_reg1            (conf_info_reg1),
        .dma_read_ctrl_valid       (dma_read_ctrl_valid),
        .dma_read_ctrl_ready       (dma_read_ctrl_ready),
        .dma_read_ctrl_data_index  (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length (dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size   (dma_read_ctrl_data_size),
        .dma_read_ctrl_data_user   (dma_read_ctrl_data_user),
        .dma_read_chnl_valid       (dma_read_chnl_valid),
        .dma_read_chnl_ready       (dma_read_chnl_ready),
        .dma_read_chnl_data        (dma_read_chnl_data),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .out_data                  (out_data),
        .out_last                  (out_last),
        .load_done                 (load_done),
        .debug                     (debug)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Scoreboard: expected requests and expected output words.
    logic [31:0] exp_req_idx[$];
    logic [31:0] exp_req_len[$];
    logic [31:0] exp_word[$];
    bit          exp_last[$];
    logic [31:0] cur_n = '0;
    int unsigned run_reqs = 0;
    int unsigned beats_run = 0;

    // Memory responder state.
    logic [31:0] bq_idx[$];
    logic [31:0] bq_len[$];
    int unsigned beat_k = 0;
    int          inflight = 0;

    // Environment modes.
    bit          ctrl_always = 1'b1;
    bit          ctrl_rand = 1'b0;
    int unsigned ctrl_delay = 0;
    bit          chnl_rand = 1'b0;
    int unsigned out_mode = 0;
    bit          zero_ok = 1'b0;

    // Monitor state.
    bit          done_armed = 1'b0;
    bit          lat_pending = 1'b0;
    logic [31:0] lat_word = '0;
    bit          prev_cv = 1'b0;
    bit          pend_cv = 1'b0;
    logic [31:0] pv_idx, pv_len;
    logic [2:0]  pv_size;
    logic [4:0]  pv_user;
    int unsigned cv_wait = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        exp_req_idx.delete();
        exp_req_len.delete();
        exp_word.delete();
        exp_last.delete();
    endtask

    // Reference model: split N words into bursts of at most BW words.
    task automatic start_run(input logic [31:0] n, input logic [31:0] b);
        logic [31:0] rem;
        logic [31:0] idx;
        logic [31:0] l;
        rem = n;
        idx = b;
        while (rem != 0) begin
            l = (rem > BW) ? BW : rem;
            exp_req_idx.push_back(idx);
            exp_req_len.push_back(l);
            idx = idx + l;
            rem = rem - l;
        end
        for (int unsigned i = 0; i < n; i++) begin
            exp_word.push_back(mem_word(b + i));
            exp_last.push_back(i == n - 1);
        end
        cur_n = n;
        run_reqs = 0;
        beats_run = 0;
        @(posedge clk); #1;
        conf_done = 1'b1;
        conf_info_reg0 = n;
        conf_info_reg1 = b;
        @(posedge clk); #1;
        conf_done = 1'b0;
    endtask

    task automatic wait_done(input int unsigned limit);
        bit seen;
        seen = 1'b0;
        for (int unsigned i = 0; i < limit && !seen; i++) begin
            @(negedge clk); #1;
            if (load_done) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_done: load_done not seen within %0d cycles", limit);
            rst = 1'b0;
            clear_model();
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
        end
        @(negedge clk); #1;
        check32("left_words", 32'(exp_word.size()), 32'd0);
        check32("left_reqs", 32'(exp_req_idx.size()), 32'd0);
    endtask

    // Bus agent and monitor: samples at negedge, drives after posedge.
    initial begin : bus
        forever begin
            @(negedge clk);
            if (!rst) begin
                bq_idx.delete();
                bq_len.delete();
                beat_k = 0;
                inflight = 0;
                done_armed = 1'b0;
                lat_pending = 1'b0;
                prev_cv = 1'b0;
                pend_cv = 1'b0;
                cv_wait = 0;
                dma_read_ctrl_ready = 1'b0;
                dma_read_chnl_valid = 1'b0;
                out_ready = 1'b0;
            end else begin
                if (!zero_ok && (done_armed || load_done)) begin
                    check32("load_done_timing", 32'(load_done), 32'(done_armed));
                    if (load_done) begin
                        check32("done_debug_state", 32'(debug[31:29]), 32'd4);
                        check32("done_debug_words", 32'(debug[28:0]), 32'(cur_n[28:0]));
                    end
                end
                done_armed = 1'b0;
                if (lat_pending) begin
                    check32("latency_valid", 32'(out_valid), 32'd1);
                    check32("latency_data", out_data, lat_word);
                    lat_pending = 1'b0;
                end
                if (pend_cv) begin
                    check32("ctrl_hold_valid", 32'(dma_read_ctrl_valid), 32'd1);
                    check32("ctrl_hold_index", dma_read_ctrl_data_index, pv_idx);
                    check32("ctrl_hold_length", dma_read_ctrl_data_length, pv_len);
                    check32("ctrl_hold_size", 32'(dma_read_ctrl_data_size), 32'(pv_size));
                    check32("ctrl_hold_user", 32'(dma_read_ctrl_data_user), 32'(pv_user));
                end
                if (dma_read_ctrl_valid && !prev_cv) begin
                    n_cmp++;
                    if (int'(FD) - inflight < int'(dma_read_ctrl_data_length)) begin
                        n_err++;
                        $display("FAIL req_free_space: length %0d with only %0d free slots",
                                 dma_read_ctrl_data_length, int'(FD) - inflight);
                    end
                end
                if (dma_read_chnl_ready) begin
                    check32("chnl_ready_without_burst", 32'(bq_len.size() != 0), 32'd1);
                end
                if (out_valid) begin
                    if (exp_word.size() == 0) begin
                        check32("out_valid_extra", 32'(out_valid), 32'd0);
                    end else begin
                        check32("out_data", out_data, exp_word[0]);
                        check32("out_last", 32'(out_last), 32'(exp_last[0]));
                    end
                end
                if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
                    if (exp_req_idx.size() == 0) begin
                        check32("req_extra", 32'(dma_read_ctrl_valid), 32'd0);
                    end else begin
                        check32("req_index", dma_read_ctrl_data_index, exp_req_idx.pop_front());
                        check32("req_length", dma_read_ctrl_data_length, exp_req_len.pop_front());
                        check32("req_size", 32'(dma_read_ctrl_data_size), 32'd2);
                        check32("req_user", 32'(dma_read_ctrl_data_user), 32'd0);
                    end
                    bq_idx.push_back(dma_read_ctrl_data_index);
                    bq_len.push_back(dma_read_ctrl_data_length);
                    run_reqs++;
                end
                if (dma_read_chnl_valid && dma_read_chnl_ready && bq_len.size() != 0) begin
                    if (inflight == 0) begin
                        lat_pending = 1'b1;
                        lat_word = dma_read_chnl_data;
                    end
                    inflight++;
                    beats_run++;
                    beat_k++;
                    if (32'(beat_k) == bq_len[0]) begin
                        void'(bq_idx.pop_front());
                        void'(bq_len.pop_front());
                        beat_k = 0;
                    end
                end
                if (out_valid && out_ready && exp_word.size() != 0) begin
                    if (exp_last[0]) done_armed = 1'b1;
                    void'(exp_word.pop_front());
                    void'(exp_last.pop_front());
                    inflight--;
                end
                prev_cv = dma_read_ctrl_valid;
                pend_cv = dma_read_ctrl_valid && !dma_read_ctrl_ready;
                pv_idx  = dma_read_ctrl_data_index;
                pv_len  = dma_read_ctrl_data_length;
                pv_size = dma_read_ctrl_data_size;
                pv_user = dma_read_ctrl_data_user;

                @(posedge clk); #1;
                if (ctrl_always) begin
                    dma_read_ctrl_ready = 1'b1;
                end else if (dma_read_ctrl_valid) begin
                    dma_read_ctrl_ready = (cv_wait >= ctrl_delay) &&
                                          (!ctrl_rand || $urandom_range(0, 1) == 1);
                    cv_wait++;
                end else begin
                    dma_read_ctrl_ready = 1'b0;
                    cv_wait = 0;
                end
                if (bq_len.size() != 0) begin
                    dma_read_chnl_valid = !chnl_rand || ($urandom_range(0, 3) != 0);
                    dma_read_chnl_data  = mem_word(bq_idx[0] + 32'(beat_k));
                end else begin
                    dma_read_chnl_valid = 1'b0;
                    dma_read_chnl_data  = $urandom;
                end
                case (out_mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ($urandom_range(0, 1) == 1);
                    default: out_ready = 1'b0;
                endcase
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : sequencer
        int unsigned cnt;
        int          first;
        int unsigned cv_seen;
        bit          got;
        logic [31:0] n;
        logic [31:0] b;

        #1 rst = 1'b0;
        @(negedge clk); #1;
        check32("rst_out_valid", 32'(out_valid), 32'd0);
        check32("rst_out_last", 32'(out_last), 32'd0);
        check32("rst_load_done", 32'(load_done), 32'd0);
        check32("rst_ctrl_valid", 32'(dma_read_ctrl_valid), 32'd0);
        check32("rst_chnl_ready", 32'(dma_read_chnl_ready), 32'd0);
        check32("rst_debug", debug, 32'd0);
        check32("rst_ctrl_index", dma_read_ctrl_data_index, 32'd0);
        check32("rst_ctrl_length", dma_read_ctrl_data_length, 32'd0);
        check32("rst_ctrl_size", 32'(dma_read_ctrl_data_size), 32'd0);
        check32("rst_ctrl_user", 32'(dma_read_ctrl_data_user), 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Single short burst, everything ready.
        start_run(32'd5, 32'h100);
        wait_done(200);
        check32("n5_requests", run_reqs, 32'd1);

        // Three bursts: 8, 8, 4.
        start_run(32'd20, 32'h0);
        wait_done(300);
        check32("n20_requests", run_reqs, 32'd3);

        // Output stalled: third burst must wait for FIFO space.
        out_mode = 2;
        start_run(32'd20, 32'h0);
        repeat (40) @(negedge clk);
        #1;
        check32("stall_requests", run_reqs, 32'd2);
        check32("stall_ctrl_valid", 32'(dma_read_ctrl_valid), 32'd0);
        check32("stall_fifo_full", 32'(beats_run), 32'd16);
        out_mode = 0;
        wait_done(300);
        check32("stall_total_requests", run_reqs, 32'd3);

        // Empty transfer.
        zero_ok = 1'b1;
        start_run(32'd0, 32'h55);
        cnt = 0;
        first = -1;
        cv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (load_done) begin
                cnt++;
                if (first < 0) first = i;
                check32("zero_debug_state", 32'(debug[31:29]), 32'd4);
            end
            if (dma_read_ctrl_valid) cv_seen++;
        end
        check32("zero_done_width", cnt, 32'd1);
        check32("zero_done_early", 32'(first >= 0 && first <= 1), 32'd1);
        check32("zero_no_ctrl", cv_seen, 32'd0);
        zero_ok = 1'b0;

        // Slow ctrl_ready plus an ignored second start.
        ctrl_always = 1'b0;
        ctrl_delay = 5;
        start_run(32'd12, 32'h2000);
        repeat (3) @(posedge clk);
        #1;
        conf_done = 1'b1;
        conf_info_reg0 = 32'd7;
        conf_info_reg1 = 32'hDEAD_0000;
        @(posedge clk); #1;
        conf_done = 1'b0;
        wait_done(400);
        check32("delay_requests", run_reqs, 32'd2);
        cv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (dma_read_ctrl_valid) cv_seen++;
        end
        check32("busy_start_ignored", cv_seen, 32'd0);

        // Randomised runs with backpressure and index wrap-around.
        for (int r = 0; r < 8; r++) begin
            ctrl_rand  = 1'b1;
            ctrl_delay = $urandom_range(0, 3);
            chnl_rand  = 1'b1;
            out_mode   = 1;
            n = 32'($urandom_range(1, 40));
            b = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            start_run(n, b);
            wait_done(3000);
        end
        ctrl_always = 1'b1;
        ctrl_rand = 1'b0;
        ctrl_delay = 0;
        chnl_rand = 1'b0;

        // Reset in the middle of a burst with three words buffered.
        out_mode = 2;
        start_run(32'd8, 32'h300);
        got = 1'b0;
        for (int unsigned i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #2;
            if (beats_run >= 3) got = 1'b1;
        end
        check32("midrst_three_buffered", 32'(got), 32'd1);
        check32("midrst_out_valid_before", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check32("midrst_out_valid", 32'(out_valid), 32'd0);
        check32("midrst_chnl_ready", 32'(dma_read_chnl_ready), 32'd0);
        check32("midrst_debug", debug, 32'd0);
        check32("midrst_ctrl_valid", 32'(dma_read_ctrl_valid), 32'd0);
        clear_model();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        out_mode = 0;
        start_run(32'd5, 32'h100);
        wait_done(200);
        check32("post_rst_requests", run_reqs, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
